// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared arbiter state encodings and picorv32 native bus widths
// ST_GNT0/ST_GNT1 are one-hot so the state register doubles as the owner output.
package mem_bus_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin choice
// Ports: req0/req1 pending requests, last index of the previous grant,
//        pick grant state to enter (ST_IDLE when nothing is requested).
module rr_pick2
   import mem_bus_pkg::*;
(
   input  logic   req0,
   input  logic   req1,
   input  logic   last,
   output state_t pick
);
   // On a tie the master that was not served last wins.
   assign pick = (req0 & (~req1 | last)) ? ST_GNT0 : req1 ? ST_GNT1 : ST_IDLE;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter for the picorv32 native memory bus
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        owner,
  output logic              timeout_flag
);
  state_t            state, next_state, pick;
  logic              last, done, tmo, gnt0, gnt1;
  logic [DATA_W-1:0] rdata;
  rr_pick2 u_pick (
    .req0 (m0_valid),
    .req1 (m1_valid),
    .last (last),
    .pick (pick)
  );
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  assign tmo   = (state != ST_IDLE) & ~s_ready & (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rdata = tmo ? TIMEOUT_DATA : s_rdata;
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE)
      wait_cnt <= '0;
    else if (!s_ready)
      wait_cnt <= wait_cnt + 16'd1;
    if (reset)
      timeout_flag <= 1'b0;
    else if (tmo)
      timeout_flag <= 1'b1;
  end
`else
  assign tmo          = 1'b0;
  assign rdata        = s_rdata;
  assign timeout_flag = 1'b0;
`endif
  assign done = s_ready | tmo;
  assign gnt0 = state == ST_GNT0;
  assign gnt1 = state == ST_GNT1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && pick != ST_IDLE)
        last <= pick == ST_GNT1;
    end
  end
  always_comb next_state = (state == ST_IDLE) ? pick : done ? ST_IDLE : state;
  assign owner    = state;
  assign s_valid  = state != ST_IDLE;
  assign s_instr  = gnt1 ? m1_instr : gnt0 & m0_instr;
  assign s_addr   = gnt1 ? m1_addr  : gnt0 ? m0_addr  : '0;
  assign s_wdata  = gnt1 ? m1_wdata : gnt0 ? m0_wdata : '0;
  assign s_wstrb  = gnt1 ? m1_wstrb : gnt0 ? m0_wstrb : '0;
  assign m0_ready = gnt0 & done;
  assign m1_ready = gnt1 & done;
  assign m0_rdata = rdata;
  assign m1_rdata = rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, corner sequences and randomized model check
module tb_mem_bus_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic        m0_ready, m1_ready, s_valid, s_instr, timeout_flag;
  logic        s_ready = 0;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata = 0;
  logic [3:0]  s_wstrb;
  logic [1:0]  owner;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .timeout_flag(timeout_flag)
  );

  typedef struct {
    logic        m0v, m1v, sr;
    logic [31:0] rd;
    logic [1:0]  own;
    logic        sv, r0, r1;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(input logic m0v, m1v, sr, input logic [31:0] rd,
                              input logic [1:0] own, input logic sv, r0, r1,
                              input logic [31:0] addr);
    vec_t v;
    v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.rd = rd; v.own = own;
    v.sv = sv; v.r0 = r0; v.r1 = r1; v.addr = addr;
    return v;
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; m0_valid = 0; m1_valid = 0; s_ready = 0;
    step;
    step;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        mv[2], mi[2], rdy_seen[2], sr;
    logic [31:0] ma[2], mw[2];
    logic [3:0]  ms[2];
    int          cur, last_g, waitc;
    int          got[$];
    tbl[0]  = mk(0, 0, 1, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 0, 1, 32'h1234_5678, 2'b01, 1, 1, 0, 32'h10);
    tbl[3]  = mk(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    tbl[4]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    tbl[5]  = mk(1, 1, 0, 32'h0,         2'b10, 1, 0, 0, 32'h200);
    tbl[6]  = mk(1, 1, 1, 32'hAAAA_5555, 2'b10, 1, 0, 1, 32'h200);
    tbl[7]  = mk(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    tbl[8]  = mk(1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 32'h10);
    tbl[9]  = mk(1, 0, 1, 32'h0BAD_F00D, 2'b01, 1, 1, 0, 32'h10);
    tbl[10] = mk(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    tbl[11] = mk(0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    tbl[12] = mk(0, 0, 0, 32'h0,         2'b10, 1, 0, 0, 32'h200);
    tbl[13] = mk(0, 0, 1, 32'h0,         2'b10, 1, 0, 1, 32'h200);
    tbl[14] = mk(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
    do_reset;
    m0_addr = 32'h10;  m0_wstrb = 4'h0;
    m1_addr = 32'h200; m1_wstrb = 4'hF; m1_wdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) step;
      m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v; s_ready = tbl[i].sr; s_rdata = tbl[i].rd;
      settle;
      chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
      chk($sformatf("tbl%0d_s_valid", i), s_valid, tbl[i].sv);
      chk($sformatf("tbl%0d_m0_ready", i), m0_ready, tbl[i].r0);
      chk($sformatf("tbl%0d_m1_ready", i), m1_ready, tbl[i].r1);
      chk($sformatf("tbl%0d_timeout_flag", i), timeout_flag, 1'b0);
      if (tbl[i].sv) chk($sformatf("tbl%0d_s_addr", i), s_addr, tbl[i].addr);
      if (tbl[i].r0 | tbl[i].r1) begin
        chk($sformatf("tbl%0d_m0_rdata", i), m0_rdata, tbl[i].rd);
        chk($sformatf("tbl%0d_m1_rdata", i), m1_rdata, tbl[i].rd);
      end
    end
    do_reset;
    m0_addr = 32'h100; m0_wdata = 32'h1111_1111; m0_wstrb = 4'hF;
    m1_addr = 32'h200; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
    m0_valid = 1; m1_valid = 1;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      if (c > 0) step;
      s_ready = s_valid;
      settle;
      if (owner == 2'b10) begin
        chk("alt_gnt1_wdata", s_wdata, 32'hA5A5_A5A5);
        chk("alt_gnt1_wstrb", s_wstrb, 4'hF);
      end
      if (owner == 2'b01) chk("alt_gnt0_wdata", s_wdata, 32'h1111_1111);
      if (m0_ready) got.push_back(0);
      if (m1_ready) got.push_back(1);
    end
    chk("alt_grant_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk($sformatf("alt_order%0d", i), got[i], i % 2);
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    do_reset;
    m1_valid = 1;
    settle;
    for (int i = 0; i < 6; i++) begin
      step;
      s_ready = (i == 5);
      if (i == 0) m0_valid = 1;
      settle;
      chk($sformatf("slow_owner%0d", i), owner, 2'b10);
      chk($sformatf("slow_m0_ready%0d", i), m0_ready, 1'b0);
      chk($sformatf("slow_m1_ready%0d", i), m1_ready, i == 5);
    end
    step;
    m1_valid = 0; s_ready = 0;
    settle;
    chk("slow_idle_owner", owner, 2'b00);
    chk("slow_idle_m0_ready", m0_ready, 1'b0);
    step;
    settle;
    chk("slow_gnt0_owner", owner, 2'b01);
    s_ready = 1;
    settle;
    chk("slow_gnt0_m0_ready", m0_ready, 1'b1);
    step;
    m0_valid = 0; s_ready = 0;
    do_reset;
    m1_valid = 1; m1_addr = 32'h300;
    settle;
    step;
    settle;
    chk("rst_gnt1_owner", owner, 2'b10);
    reset = 1;
    step;
    reset = 0; m0_valid = 1; s_ready = 1;
    settle;
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_m1_ready", m1_ready, 1'b0);
    chk("rst_m0_ready", m0_ready, 1'b0);
    step;
    s_ready = 0;
    settle;
    chk("rst_tie_m0", owner, 2'b01);
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    do_reset;
    m0_valid = 1; m0_addr = 32'h40; m1_valid = 0;
    settle;
    for (int k = 1; k <= 8; k++) begin
      step;
      settle;
      chk($sformatf("tmo_owner%0d", k), owner, 2'b01);
      chk($sformatf("tmo_m0_ready%0d", k), m0_ready, k == 8);
      chk($sformatf("tmo_flag%0d", k), timeout_flag, 1'b0);
      if (k == 8) chk("tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
    end
    step;
    m0_valid = 0;
    settle;
    chk("tmo_after_owner", owner, 2'b00);
    chk("tmo_after_flag", timeout_flag, 1'b1);
    m1_valid = 1;
    step;
    s_ready = 1; s_rdata = 32'h600D_F00D;
    settle;
    chk("tmo_m1_owner", owner, 2'b10);
    chk("tmo_m1_ready", m1_ready, 1'b1);
    chk("tmo_m1_rdata", m1_rdata, 32'h600D_F00D);
    step;
    m1_valid = 0; s_ready = 0;
    settle;
    chk("tmo_flag_sticky", timeout_flag, 1'b1);
`endif
    do_reset;
    cur = -1; last_g = 1; waitc = 0;
    for (int n = 0; n < 2; n++) begin
      mv[n] = 0; mi[n] = 0; ma[n] = 0; mw[n] = 0; ms[n] = 0; rdy_seen[n] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) step;
      for (int n = 0; n < 2; n++) begin
        if (rdy_seen[n]) mv[n] = 0;
        if (!mv[n] && $urandom_range(0, 2) == 0) begin
          mv[n] = 1; mi[n] = 1'($urandom_range(0, 1)); ma[n] = $urandom;
          mw[n] = $urandom; ms[n] = 4'($urandom_range(0, 15));
        end
      end
      sr = (cur >= 0 && waitc >= 4) ? 1'b1 : ($urandom_range(0, 2) == 0);
      m0_valid = mv[0]; m0_instr = mi[0]; m0_addr = ma[0]; m0_wdata = mw[0]; m0_wstrb = ms[0];
      m1_valid = mv[1]; m1_instr = mi[1]; m1_addr = ma[1]; m1_wdata = mw[1]; m1_wstrb = ms[1];
      s_ready = sr;
      s_rdata = (cur >= 0) ? slave_data(ma[cur]) : $urandom;
      settle;
      chk("rand_owner", owner, cur < 0 ? 2'b00 : (cur == 0 ? 2'b01 : 2'b10));
      chk("rand_s_valid", s_valid, cur >= 0);
      chk("rand_m0_ready", m0_ready, cur == 0 && sr);
      chk("rand_m1_ready", m1_ready, cur == 1 && sr);
      if (cur >= 0) begin
        chk("rand_s_addr_wdata", {s_addr, s_wdata}, {ma[cur], mw[cur]});
        chk("rand_s_wstrb_instr", {s_wstrb, s_instr}, {ms[cur], mi[cur]});
        if (sr) chk("rand_rdata", cur == 0 ? m0_rdata : m1_rdata, slave_data(ma[cur]));
      end
      rdy_seen[0] = m0_ready; rdy_seen[1] = m1_ready;
      if (cur >= 0) begin
        waitc++;
        if (sr) cur = -1;
      end else if (mv[0] || mv[1]) begin
        cur = (mv[0] && mv[1]) ? 1 - last_g : (mv[0] ? 0 : 1);
        last_g = cur;
        waitc = 0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
